// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch types, epoch sentinel and queue entry layout
package fetch_queue_pkg;
  typedef logic [31:0] rvwordT;
  typedef logic [1:0] EpochT;
  localparam EpochT EPOCH_INVALID = 2'b11;
  typedef struct packed {
    rvwordT pc;
    rvwordT instr;
    EpochT  epoch;
  } FetchQEntryT;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: epoch-filtered instruction queue between imem response and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH       = 4,
  parameter EpochT RESET_EPOCH = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  rvwordT                   in_pc,
  input  EpochT                    in_epoch,
  input  rvwordT                   in_instr,
  input  EpochT                    jumpEpoch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output rvwordT                   out_pc,
  output rvwordT                   out_instr,
  output EpochT                    out_epoch,
  output logic                     fq_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  FetchQEntryT   r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  EpochT         r_epoch;
  logic          r_ovf;
  logic          w_flush, w_deq, w_match, w_free, w_enq;
  FetchQEntryT   w_head;
  assign w_flush      = jumpEpoch != EPOCH_INVALID;
  assign w_deq        = out_valid && out_ready;
  assign w_match      = in_valid && (in_epoch == r_epoch) && (in_epoch != EPOCH_INVALID);
  assign w_free       = (r_count < CW'(DEPTH)) || w_deq;
  assign w_enq        = w_match && w_free && !w_flush;
  assign w_head       = r_mem[r_head];
  assign out_valid    = (r_count != '0) && !w_flush;
  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_epoch    = w_head.epoch;
  assign fq_stall     = r_count >= CW'(DEPTH - 1);
  assign count        = r_count;
  assign overflow_err = r_ovf;
  // Storage is deliberately not reset; contents are meaningless while count is zero
  always_ff @(posedge clk)
    if (w_enq) r_mem[r_tail] <= '{pc: in_pc, instr: in_instr, epoch: in_epoch};
  // Pointers, occupancy, epoch and sticky overflow; a flush wins over any enqueue/dequeue
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_epoch <= RESET_EPOCH;
      r_ovf   <= 1'b0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_epoch <= jumpEpoch;
    end else begin
      r_head  <= w_deq ? r_head + AW'(1) : r_head;
      r_tail  <= w_enq ? r_tail + AW'(1) : r_tail;
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      r_ovf   <= r_ovf || (w_match && !w_free);
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  rvwordT      in_pc = '0;
  EpochT       in_epoch = '0;
  rvwordT      in_instr = '0;
  EpochT       jumpEpoch = EPOCH_INVALID;
  logic        out_valid;
  logic        out_ready = 1'b0;
  rvwordT      out_pc, out_instr;
  EpochT       out_epoch;
  logic        fq_stall;
  logic [2:0]  count;
  logic        overflow_err;
  int          vectors = 0;
  int          miscompares = 0;
  FetchQEntryT m_q[$];
  EpochT       m_epoch = '0;
  logic        m_ovf = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_EPOCH(2'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_epoch(in_epoch),
    .in_instr(in_instr), .jumpEpoch(jumpEpoch), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_epoch(out_epoch), .fq_stall(fq_stall),
    .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input rvwordT pc, input EpochT ep, input logic rdy, input EpochT jmp);
    in_valid  = v;
    in_pc     = pc;
    in_epoch  = ep;
    in_instr  = pc ^ 32'hA5A5_0000;
    out_ready = rdy;
    jumpEpoch = jmp;
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (m_q.size() != 0) && (jumpEpoch == EPOCH_INVALID);
    chk("out_valid", out_valid, exp_v);
    chk("count", count, m_q.size());
    chk("fq_stall", fq_stall, m_q.size() >= DEPTH - 1);
    chk("overflow_err", overflow_err, m_ovf);
    if (exp_v) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
      chk("out_epoch", out_epoch, m_q[0].epoch);
    end
  endtask

  // Check the current cycle, advance the model by the stated rules, then cross one clock edge
  task automatic tick();
    logic deq, match, free;
    #1;
    check_outputs();
    if (jumpEpoch != EPOCH_INVALID) begin
      m_q.delete();
      m_epoch = jumpEpoch;
    end else begin
      deq   = (m_q.size() != 0) && out_ready;
      match = in_valid && (in_epoch == m_epoch) && (in_epoch != EPOCH_INVALID);
      free  = (m_q.size() < DEPTH) || deq;
      if (deq) void'(m_q.pop_front());
      if (match && free) m_q.push_back('{pc: in_pc, instr: in_instr, epoch: in_epoch});
      if (match && !free) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_q.delete();
    m_epoch = '0;
    m_ovf   = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fq_stall", fq_stall, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    // Fill to four with epoch 0, decode stalled
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'h10 + 32'(i * 4), 2'd0, 1'b0, EPOCH_INVALID);
      tick();
    end
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    // Full queue, simultaneous enqueue and dequeue keeps occupancy
    drv(1'b1, 32'h20, 2'd0, 1'b1, EPOCH_INVALID);
    tick();
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    // Full queue, one more matching response overflows
    drv(1'b1, 32'h24, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    // Drain and confirm order
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, '0, 2'd0, 1'b1, EPOCH_INVALID);
      tick();
    end
    do_reset();
    // Two queued, then flush with decode ready
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h40 + 32'(i * 4), 2'd0, 1'b0, EPOCH_INVALID);
      tick();
    end
    drv(1'b0, '0, 2'd0, 1'b1, 2'd1);
    tick();
    // First cycle after flush: new-epoch response accepted
    drv(1'b1, 32'h100, 2'd1, 1'b0, EPOCH_INVALID);
    tick();
    drv(1'b1, 32'h200, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    // Six enqueue/dequeue pairs to wrap the pointers
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 32'h300 + 32'(i * 4), 2'd1, 1'b1, EPOCH_INVALID);
      tick();
    end
    drv(1'b0, '0, 2'd1, 1'b1, EPOCH_INVALID);
    tick();
    tick();
    // Three entries, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'h500 + 32'(i * 4), 2'd1, 1'b0, EPOCH_INVALID);
      tick();
    end
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    #1;
    check_outputs();
    #2;
    do_reset();
    drv(1'b1, 32'h600, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    drv(1'b0, '0, 2'd0, 1'b0, EPOCH_INVALID);
    tick();
    // Randomized traffic with stale epochs, flushes and varying decode back-pressure
    for (int i = 0; i < 1500; i++) begin
      drv($urandom_range(0, 3) != 0,
          $urandom,
          ($urandom_range(0, 3) == 0) ? EpochT'($urandom_range(0, 3)) : m_epoch,
          $urandom_range(0, 99) < ((i / 100) % 2 ? 30 : 70),
          ($urandom_range(0, 31) == 0) ? EpochT'($urandom_range(0, 2)) : EPOCH_INVALID);
      tick();
      if (i % 400 == 399) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
